// File: rtl/regfile_1hot_16.sv
// 16-entry register file written through a one-hot select, with two registered read ports
// and a 16-cycle clear sweep. Define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_1hot_16 #(
    parameter int unsigned DATA_W  = 16,
    parameter bit          R0_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [15:0]       wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              sel_err
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [16];
    logic [DATA_W-1:0] mem_d [16];
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;
    logic              sel_err_q, sel_err_d;

    logic       idle;
    logic       sel_onehot;
    logic       wr_hit;
    logic       clr_hit;
    logic [3:0] wr_idx;

    assign idle       = (state_q == StIdle);
    assign sel_onehot = $onehot(wr_sel);
    // Entry 0 is hard-wired to zero when R0_ZERO is set, so such writes are silently dropped.
    assign wr_hit     = idle && wr_en && sel_onehot && !(R0_ZERO && wr_sel[0]);

    always_comb begin
        wr_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (wr_sel[i]) wr_idx = 4'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                clr_hit = 1'b1;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_hit)  mem_d[wr_idx] = wr_data;
        if (clr_hit) mem_d[cnt_q]  = '0;
    end

    assign sel_err_d = idle && wr_en && !sel_onehot;

    always_comb begin
        rd_a_d = mem_q[rd_addr_a];
        rd_b_d = mem_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        // wr_hit already excludes the sweep and the zero entry, so forwarding obeys both rules.
        if (wr_hit && (rd_addr_a == wr_idx)) rd_a_d = wr_data;
        if (wr_hit && (rd_addr_b == wr_idx)) rd_b_d = wr_data;
`endif
        if (R0_ZERO && (rd_addr_a == 4'd0)) rd_a_d = '0;
        if (R0_ZERO && (rd_addr_b == 4'd0)) rd_b_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            sel_err_q <= 1'b0;
            for (int i = 0; i < 16; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            sel_err_q <= sel_err_d;
            for (int i = 0; i < 16; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign rd_data_a = rd_a_q;
    assign rd_data_b = rd_b_q;
    assign sel_err   = sel_err_q;
    assign busy      = (state_q == StClear);

endmodule

// File: tb/tb_regfile_1hot_16.sv
// Randomized plus directed bench for regfile_1hot_16; instance 0 has R0_ZERO=0, instance 1 has
// R0_ZERO=1, both checked against an array-based reference model each cycle.
module tb_regfile_1hot_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_sel;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        clr_req;
    logic [15:0] rd_a [2];
    logic [15:0] rd_b [2];
    logic        busy [2];
    logic        err  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: storage, remaining sweep cycles, expected outputs.
    logic [15:0] mm   [2][16];
    int          left [2];
    logic [15:0] ea   [2];
    logic [15:0] eb   [2];
    logic        ee   [2];

    always #5 clk = ~clk;

    regfile_1hot_16 #(.DATA_W(16), .R0_ZERO(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a[0]), .rd_data_b(rd_b[0]),
        .clr_req(clr_req), .busy(busy[0]), .sel_err(err[0])
    );

    regfile_1hot_16 #(.DATA_W(16), .R0_ZERO(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a[1]), .rd_data_b(rd_b[1]),
        .clr_req(clr_req), .busy(busy[1]), .sel_err(err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            left[k] = 0;
            ea[k] = '0;
            eb[k] = '0;
            ee[k] = 1'b0;
            for (int i = 0; i < 16; i++) mm[k][i] = '0;
        end
    endtask

    task automatic model_step();
        bit legal, r0;
        int widx;
        widx = 0;
        for (int i = 0; i < 16; i++) if (wr_sel == (16'd1 << i)) widx = i;
        for (int k = 0; k < 2; k++) begin
            r0    = (k == 1);
            legal = (left[k] == 0) && wr_en && ($countones(wr_sel) == 1) && !(r0 && widx == 0);
            ea[k] = (r0 && rd_addr_a == 0) ? 16'h0 : mm[k][rd_addr_a];
            eb[k] = (r0 && rd_addr_b == 0) ? 16'h0 : mm[k][rd_addr_b];
`ifdef REGFILE_BYPASS_EN
            if (legal && int'(rd_addr_a) == widx) ea[k] = wr_data;
            if (legal && int'(rd_addr_b) == widx) eb[k] = wr_data;
`endif
            ee[k] = (left[k] == 0) && wr_en && ($countones(wr_sel) != 1);
            if (left[k] > 0) begin
                mm[k][16 - left[k]] = '0;
                left[k]--;
            end else begin
                if (legal) mm[k][widx] = wr_data;
                if (clr_req) left[k] = 16;
            end
        end
    endtask

    task automatic cycle(input logic we, input logic [15:0] sel, input logic [15:0] data,
                         input logic [3:0] ra, input logic [3:0] rb, input logic clr);
        wr_en = we; wr_sel = sel; wr_data = data;
        rd_addr_a = ra; rd_addr_b = rb; clr_req = clr;
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rd_a[%0d]", k), 32'(rd_a[k]), 32'(ea[k]));
            check_eq($sformatf("rd_b[%0d]", k), 32'(rd_b[k]), 32'(eb[k]));
            check_eq($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(left[k] > 0));
            check_eq($sformatf("sel_err[%0d]", k), 32'(err[k]), 32'(ee[k]));
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic mid_reset();
        wr_en = 1'b0; clr_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_rd_a[%0d]", k), 32'(rd_a[k]), 32'h0);
            check_eq($sformatf("rst_rd_b[%0d]", k), 32'(rd_b[k]), 32'h0);
            check_eq($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'h0);
            check_eq($sformatf("rst_err[%0d]", k), 32'(err[k]), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_sel();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 16'd1 << $urandom_range(0, 15);
        if (r == 6) return 16'h0;
        if (r == 7) return (16'd1 << $urandom_range(0, 7)) | (16'd1 << $urandom_range(8, 15));
        return 16'($urandom);
    endfunction

    initial begin
        int n_busy;
        int guard;
        rst_n = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        mid_reset();

        // Write entry 3, then reset mid-cycle; entry 3 must read back as zero.
        cycle(1'b1, 16'h0008, 16'hBEEF, 4'd0, 4'd0, 1'b0);
        mid_reset();
        cycle(1'b0, 16'h0000, 16'h0000, 4'd3, 4'd3, 1'b0);
        check_eq("rst_entry3", 32'(rd_a[0]), 32'h0);

        // Decoder index 5 write, read back one cycle later.
        cycle(1'b1, 16'h0020, 16'h1234, 4'd0, 4'd0, 1'b0);
        cycle(1'b0, 16'h0000, 16'h0000, 4'd5, 4'd4, 1'b0);
        check_eq("wr5_rd_a", 32'(rd_a[0]), 32'h1234);
        check_eq("wr5_rd_b", 32'(rd_b[0]), 32'h0);

        // Back-to-back illegal selects.
        cycle(1'b1, 16'h0000, 16'hDEAD, 4'd0, 4'd4, 1'b0);
        check_eq("illegal_zero", 32'(err[0]), 32'h1);
        cycle(1'b1, 16'h0011, 16'hDEAD, 4'd0, 4'd4, 1'b0);
        check_eq("illegal_two", 32'(err[0]), 32'h1);
        cycle(1'b0, 16'hFFFF, 16'hDEAD, 4'd0, 4'd4, 1'b0);
        check_eq("illegal_clear", 32'(err[0]), 32'h0);
        check_eq("illegal_e0", 32'(rd_a[0]), 32'h0);
        check_eq("illegal_e4", 32'(rd_b[0]), 32'h0);

        // Clear sweep with a restart request and a dropped write in the middle.
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'd1 << i, 16'hA5A5, 4'd0, 4'd0, 1'b0);
        cycle(1'b0, 16'h0000, 16'h0000, 4'd0, 4'd15, 1'b1);
        n_busy = busy[0] ? 1 : 0;
        guard = 0;
        while (busy[0] && guard < 40) begin
            cycle(n_busy == 7, 16'h0004, 16'h7777, 4'd2, 4'd15, n_busy == 5);
            guard++;
            if (busy[0]) n_busy++;
            if (n_busy == 10 && busy[0]) check_eq("sweep_e15_mid", 32'(rd_b[0]), 32'hA5A5);
        end
        check_eq("busy_len", 32'(n_busy), 32'd16);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 16'h0000, 16'h0000, 4'(i), 4'(15 - i), 1'b0);
            check_eq($sformatf("swept_e%0d", i), 32'(rd_a[0]), 32'h0);
        end

        // Same-cycle write/read collision on port B.
        cycle(1'b1, 16'h0200, 16'h1111, 4'd0, 4'd0, 1'b0);
        cycle(1'b1, 16'h0200, 16'h00FF, 4'd0, 4'd9, 1'b0);
`ifdef REGFILE_BYPASS_EN
        check_eq("raw_first", 32'(rd_b[0]), 32'h00FF);
`else
        check_eq("raw_first", 32'(rd_b[0]), 32'h1111);
`endif
        cycle(1'b0, 16'h0000, 16'h0000, 4'd0, 4'd9, 1'b0);
        check_eq("raw_second", 32'(rd_b[0]), 32'h00FF);

        // Zero entry on the R0_ZERO instance.
        cycle(1'b1, 16'h0001, 16'hFFFF, 4'd0, 4'd0, 1'b0);
        check_eq("r0_err", 32'(err[1]), 32'h0);
        check_eq("r0_byp_a", 32'(rd_a[1]), 32'h0);
        cycle(1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0);
        check_eq("r0_rd_a", 32'(rd_a[1]), 32'h0);
        check_eq("r0_rd_b", 32'(rd_b[1]), 32'h0);
        check_eq("nor0_rd_a", 32'(rd_a[0]), 32'hFFFF);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) mid_reset();
            cycle($urandom_range(0, 9) < 6, rand_sel(), 16'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_1hot_16.md
Name: regfile_1hot_16

Overview:
- 16-entry general register file sitting directly downstream of the 4-to-16 one-hot decoder.
- The decoder's 16-bit one-hot output drives wr_sel and selects the write target.
- Provides two registered read ports, a one-hot legality check on wr_sel, and a sequenced 16-cycle clear engine used at mode changes.

Parameters:
- DATA_W, 16, width of each register and of the data ports.
- R0_ZERO, 0, when 1, entry 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request, sampled at the clk edge.
- wr_sel  input  16  one-hot write target from the decoder; bit i selects entry i.
- wr_data  input  DATA_W  write data.
- rd_addr_a  input  4  read port A index.
- rd_addr_b  input  4  read port B index.
- rd_data_a  output  DATA_W  registered read data, port A.
- rd_data_b  output  DATA_W  registered read data, port B.
- clr_req  input  1  single-cycle request to start a clear sweep.
- busy  output  1  high while a clear sweep is in progress.
- sel_err  output  1  one-cycle pulse flagging an illegal wr_sel.

Behaviour:
- Reset: rst_n low asynchronously forces the following, independent of clk:
  - all 16 entries = 0, rd_data_a = 0, rd_data_b = 0;
  - busy = 0, sel_err = 0;
  - FSM = IDLE, clear counter = 0.
- Reset mid-sweep aborts the sweep; the block is in IDLE after rst_n rises.
- Write, IDLE state only:
  - Condition: wr_en = 1 and wr_sel has exactly one bit set.
  - Entry i takes wr_data at the edge; visible in storage the next cycle.
  - If R0_ZERO = 1 and wr_sel = 0x0001, the write is dropped silently (no sel_err).
- Illegal select:
  - Condition: wr_en = 1 and wr_sel is zero or has more than one bit set.
  - No entry changes; sel_err = 1 on the following cycle for exactly one cycle.
  - Back-to-back illegal writes give sel_err high on consecutive cycles.
  - When wr_en = 0, wr_sel is don't-care and sel_err stays 0.
- Reads:
  - rd_data_x is registered from entry[rd_addr_x] at each edge: 1-cycle latency.
  - Both ports are independent; the same index on both ports is legal.
  - Same-cycle write/read collision: handled per the REGFILE_BYPASS_EN option below.
  - R0_ZERO = 1 and index 0: read returns 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req = 1. The counter loads 0; busy rises on the next cycle.
  - CLEAR: each cycle, entry[counter] <= 0 and counter increments. On counter = 15 the entry is zeroed and the FSM returns to IDLE.
  - busy is high for exactly 16 cycles.
  - clr_req during CLEAR: ignored; no restart, no extension.
  - wr_en during CLEAR: write dropped. sel_err is not raised, even when wr_sel is illegal.
  - Reads during CLEAR continue, returning current storage: already-swept entries read 0.
  - clr_req and a legal write in the same IDLE cycle: the write is applied first, then the sweep starts next cycle, so the entry ends at 0.
- Widths:
  - The counter is 4 bits and wraps 15 -> 0 only on exit to IDLE.
  - No arithmetic is performed on data.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read whose index matches a legal write in the same cycle registers wr_data. Read-after-write latency is therefore 1 cycle. Bypass is suppressed for entry 0 when R0_ZERO = 1, and suppressed while busy.
- Undefined: such a read registers the old entry value. The new value appears on a read issued the next cycle (effective RAW latency 2).

Test Plan:
- Reset clears state: set wr_sel = 0x0008 with wr_en, write 0xBEEF to entry 3, then assert rst_n low mid-cycle -> rd_data_a/b = 0 immediately and busy = 0. After release, reading index 3 returns 0x0000.
- Write/read through the decoder: feed decoder index 5, write 0x1234, next cycle rd_addr_a = 5 -> rd_data_a = 0x1234 one cycle later. Port B at index 4 reads 0x0000.
- Illegal select: wr_en with wr_sel = 0x0000, then wr_sel = 0x0011 -> sel_err high for 2 consecutive cycles. Entries 0 and 4 are unchanged.
- Clear sweep: preload all 16 entries with 0xA5A5, pulse clr_req -> busy high for exactly 16 cycles.
  - Index 15 still reads 0xA5A5 at the 10th busy cycle.
  - After busy falls, all entries read 0.
  - clr_req pulsed mid-sweep does not extend busy.
  - A write of 0x7777 to index 2 during busy is dropped.
- Bypass collision: write 0x00FF to index 9 while rd_addr_b = 9.
  - With REGFILE_BYPASS_EN: rd_data_b = 0x00FF next cycle.
  - Without it: rd_data_b shows the old value, then 0x00FF one cycle later.
- R0_ZERO = 1: write 0xFFFF with wr_sel = 0x0001 -> sel_err stays 0, and index 0 reads 0x0000 on both ports, with and without bypass.
